// File: rtl/bus_cycle_arbiter.sv
// rtl/bus_cycle_arbiter.sv - two-requester round-robin bus master sequencing T1-T2-T3-(Tw)-T4 cycles
module bus_cycle_arbiter #(
  parameter logic [19:0] MEM0_HI  = 20'h7FFFF,
  parameter logic [19:0] MEM1_LO  = 20'h80000,
  parameter logic [19:0] MEM1_HI  = 20'hFFFFF,
  parameter logic [19:0] IO0_LO   = 20'h00000,
  parameter logic [19:0] IO0_HI   = 20'h000FF,
  parameter logic [19:0] IO1_LO   = 20'h00100,
  parameter logic [19:0] IO1_HI   = 20'h001FF,
  parameter int          MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req0_valid,
  input  logic        req0_iom,
  input  logic        req0_wr,
  input  logic [19:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_iom,
  input  logic        req1_wr,
  input  logic [19:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        ack0,
  output logic        err0,
  output logic        ack1,
  output logic        err1,
  output logic [7:0]  rdata,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic [19:0] Address,
  output logic [7:0]  Data_out,
  output logic        Data_oe,
  input  logic [7:0]  Data_in,
  input  logic        READY,
  output logic [3:0]  CS
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T1    = 3'd1,
    S_T2    = 3'd2,
    S_T3    = 3'd3,
    S_TW    = 3'd4,
    S_T4    = 3'd5,
    S_ERR   = 3'd6,
    S_ABORT = 3'd7
  } state_t;

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           rr_last_q, rr_last_d;
  logic           iom_q, iom_d;
  logic           wr_q, wr_d;
  logic [19:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [3:0]     cs_q, cs_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [WW-1:0]  wait_q, wait_d;

  logic           pick;
  logic           sel_iom;
  logic           sel_wr;
  logic [19:0]    sel_addr;
  logic [7:0]     sel_wdata;
  logic [3:0]     dec_cs;

  function automatic logic in_range(input logic [19:0] a, input logic [19:0] lo,
                                    input logic [19:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  // Priority order makes overlapping windows resolve to the lower index.
  function automatic logic [3:0] decode(input logic iom, input logic [19:0] a);
    logic [3:0] cs;
    cs = 4'b0000;
    if (!iom) begin
      if (in_range(a, 20'h00000, MEM0_HI))   cs = 4'b0001;
      else if (in_range(a, MEM1_LO, MEM1_HI)) cs = 4'b0010;
    end else begin
      if (in_range(a, IO0_LO, IO0_HI))       cs = 4'b0100;
      else if (in_range(a, IO1_LO, IO1_HI))  cs = 4'b1000;
    end
    return cs;
  endfunction

  // Sole requester wins; on a tie the one not granted last wins.
  always_comb begin
    pick      = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
    sel_iom   = pick ? req1_iom   : req0_iom;
    sel_wr    = pick ? req1_wr    : req0_wr;
    sel_addr  = pick ? req1_addr  : req0_addr;
    sel_wdata = pick ? req1_wdata : req0_wdata;
    dec_cs    = decode(sel_iom, sel_addr);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    iom_d     = iom_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cs_d      = cs_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d     = pick;
          rr_last_d = pick;
          if (|dec_cs) begin
            state_d = S_T1;
            iom_d   = sel_iom;
            wr_d    = sel_wr;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            cs_d    = dec_cs;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      S_T1:    state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        wait_d  = '0;
      end
      S_T3: begin
        if (READY) begin
          if (!wr_q) rdata_d = Data_in;
          state_d = S_T4;
        end else begin
          state_d = S_TW;
        end
      end
      S_TW: begin
        if (READY) begin
          if (!wr_q) rdata_d = Data_in;
          state_d = S_T4;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ABORT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        cs_d    = 4'b0000;
      end
      S_T4: begin
        state_d = S_IDLE;
        cs_d    = 4'b0000;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      iom_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs_q      <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      iom_q     <= iom_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cs_q      <= cs_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
    end
  end

  // Bus pins decode straight from state so an async reset releases them at once.
  logic in_cycle;
  logic strobe;
  logic fail_st;

  always_comb begin
    in_cycle = (state_q == S_T1) || (state_q == S_T2) || (state_q == S_T3) ||
               (state_q == S_TW) || (state_q == S_T4);
    strobe   = (state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW);
    fail_st  = (state_q == S_ERR) || (state_q == S_ABORT);
  end

  assign ALE      = (state_q == S_T1);
  assign RD       = ~(strobe && !wr_q);
  assign WR       = ~(strobe && wr_q);
  assign Data_oe  = wr_q && (strobe || (state_q == S_T4));
  assign CS       = in_cycle ? cs_q : 4'b0000;
  assign IOM      = iom_q;
  assign Address  = addr_q;
  assign Data_out = wdata_q;
  assign rdata    = rdata_q;
  assign ack0     = (state_q == S_T4) && !gnt_q;
  assign ack1     = (state_q == S_T4) &&  gnt_q;
  assign err0     = fail_st && !gnt_q;
  assign err1     = fail_st &&  gnt_q;

endmodule

// File: doc/bus_cycle_arbiter.md
Name: bus_cycle_arbiter

Overview:
- Bus master front end for the 8088-style peripheral bus.
- Arbitrates between two requesters (req0 = CPU model, req1 = DMA/testbench agent) with round-robin priority.
- Decodes the target address into a one-hot chip select for mem0/mem1/io0/io1.
- Sequences a full T1-T2-T3-(Tw)-T4 bus cycle (ALE, RD, WR, IOM, address/data) and returns ack/err plus read data to the granted requester.

Parameters:
- MEM0_HI, 20'h7FFFF, mem0 occupies 0..MEM0_HI (memory space).
- MEM1_LO, 20'h80000, mem1 low bound (memory space).
- MEM1_HI, 20'hFFFFF, mem1 high bound.
- IO0_LO, 20'h00000, io0 low bound (IO space).
- IO0_HI, 20'h000FF, io0 high bound.
- IO1_LO, 20'h00100, io1 low bound (IO space).
- IO1_HI, 20'h001FF, io1 high bound.
- MAX_WAIT, 8, maximum Tw cycles before abort.

Ports:
- CLK  in  1  bus clock
- RESET  in  1  asynchronous, active-high reset
- reqN_valid (N=0,1)  in  1  request pending; held until ackN or errN
- reqN_iom  in  1  1 = IO space, 0 = memory space
- reqN_wr  in  1  1 = write, 0 = read
- reqN_addr  in  20  target address
- reqN_wdata  in  8  write data
- ackN  out  1  one-cycle completion pulse
- errN  out  1  one-cycle pulse: unmapped address or wait timeout
- rdata  out  8  read data; valid while ackN=1 for a read
- ALE  out  1  address latch enable, high in T1 only
- RD  out  1  active-low read strobe
- WR  out  1  active-low write strobe
- IOM  out  1  mirrors granted reqN_iom for the whole cycle
- Address  out  20  bus address, held T1..T4
- Data_out  out  8  write data to bus
- Data_oe  out  1  master drives Data, T2..T4 of writes only
- Data_in  in  8  bus data for reads
- READY  in  1  peripheral ready, sampled in T3/Tw
- CS  out  4  one-hot select: bit0 mem0, bit1 mem1, bit2 io0, bit3 io1

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ALE=0, RD=1, WR=1, Data_oe=0, CS=0, IOM=0, Address=0, Data_out=0, ack/err=0, rdata=0, rr_last=1 (req0 wins first).
- States and transitions:
  - IDLE: if any valid, grant (round-robin: the requester not granted last wins ties; a sole requester always wins). Decode address with iom. Decode hit -> T1. No hit -> ERR.
  - ERR: errN=1 for one cycle, no bus activity, then -> IDLE.
  - T1: ALE=1; Address, IOM, CS registered and held through T4. -> T2.
  - T2: RD=0 (read) or WR=0 (write); Data_oe=1 and Data_out=wdata for writes. -> T3.
  - T3: READY=1 -> T4, capturing Data_in into rdata for reads. READY=0 -> TW.
  - TW: strobes held. READY=1 -> T4 (capture as in T3). Wait count reaching MAX_WAIT with READY=0 -> ABORT.
  - ABORT: strobes released, errN pulse, CS cleared -> IDLE.
  - T4: RD=WR=1, ackN=1, rdata valid, Data_oe still 1 for writes (hold time). -> IDLE; CS and Data_oe clear on exit.
- Latency: request seen in IDLE at cycle k gives T1 at k+1, T4/ack at k+4 with READY=1. Each Tw adds one cycle. At least one IDLE cycle between bus cycles.
- Decode rules:
  - Memory space checks mem0, then mem1; IO space checks io0, then io1.
  - Bounds are inclusive. Overlapping ranges resolve to the lower index.
  - CS is never multi-hot.
- Request fields are latched at grant. Changes to valid or fields during a cycle do not affect it. Dropping valid mid-cycle does not cancel it; ack is still pulsed.
- rr_last updates at grant, including for the error path.
- RD and WR are never low simultaneously. ALE is never high while either strobe is low.

Test Plan:
- req0 read iom=0 addr=20'h00010, READY=1, Data_in=8'hA5 -> ALE at k+1, RD low k+2..k+3, CS=4'b0001, ack0 at k+4, rdata=8'hA5.
- req1 write iom=1 addr=20'h00120 wdata=8'h3C, READY low 2 cycles -> CS=4'b1000, IOM=1, WR low 4 cycles, Data_oe high T2..T4 with Data_out=8'h3C, ack1 at k+6.
- req0 and req1 held valid continuously, both reads -> grants alternate 0,1,0,1; each ack spaced 5 cycles apart.
- req0 iom=1 addr=20'h00300 (unmapped) -> err0 one cycle after grant; ALE, RD, WR never asserted; CS stays 0.
- READY held 0 -> exactly MAX_WAIT=8 Tw cycles, then RD high, err0 pulse, no ack0.
- RESET asserted mid-TW -> RD=1, CS=0, Data_oe=0 immediately (asynchronously); after release, req0 granted first.
